// File: rtl/platform_scheduler_if.sv
// Handshake bundle for platform_scheduler: frame strobe, level-load configuration
// port and the per-platform motion outputs read by the ball/player logic.
interface platform_scheduler_if #(
   parameter int NUM_PLAT = 4
);
   localparam int IW = $clog2(NUM_PLAT);

   logic                 frame_tick;
   logic                 cfg_we;
   logic [IW-1:0]        cfg_idx;
   logic [9:0]           cfg_xmin;
   logic [9:0]           cfg_xmax;
   logic [2:0]           cfg_speed;
   logic                 cfg_en;
   logic                 cfg_ack;
   logic [9:0]           plat_x   [NUM_PLAT];
   logic                 plat_dir [NUM_PLAT];
   logic signed [10:0]   plat_dx  [NUM_PLAT];
   logic                 busy;
   logic                 update_done;
   logic                 overrun;

   modport master (
      output frame_tick, cfg_we, cfg_idx, cfg_xmin, cfg_xmax, cfg_speed, cfg_en,
      input  cfg_ack, plat_x, plat_dir, plat_dx, busy, update_done, overrun
   );

   modport slave (
      input  frame_tick, cfg_we, cfg_idx, cfg_xmin, cfg_xmax, cfg_speed, cfg_en,
      output cfg_ack, plat_x, plat_dir, plat_dx, busy, update_done, overrun
   );
endinterface

// File: rtl/platform_scheduler.sv
// Per-frame platform motion scheduler: one shared step/clamp datapath visits each platform in turn.
// Define PLAT_DWELL_EN to add per-platform dwell counters that pause DWELL frames at each bound.
module platform_scheduler #(
   parameter int NUM_PLAT = 4,
   parameter int DWELL    = 30,
   parameter int P0_XMIN  = 180,
   parameter int P0_XMAX  = 305
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   platform_scheduler_if.slave  bus
);
   localparam int              IW         = $clog2(NUM_PLAT);
   localparam logic [IW-1:0]   LAST_IDX   = IW'(NUM_PLAT - 1);
   localparam logic [IW:0]     NUM_PLAT_V = (IW + 1)'(NUM_PLAT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [IW-1:0]       r_idx;
   logic                r_busy;
   logic                r_cfg_ack;
   logic                r_update_done;
   logic                r_overrun;

   logic [9:0]          r_x     [NUM_PLAT];
   logic [9:0]          r_xmin  [NUM_PLAT];
   logic [9:0]          r_xmax  [NUM_PLAT];
   logic [2:0]          r_speed [NUM_PLAT];
   logic                r_en    [NUM_PLAT];
   logic                r_dir   [NUM_PLAT];
   logic signed [10:0]  r_dx    [NUM_PLAT];

`ifdef PLAT_DWELL_EN
   localparam logic [7:0] DWELL_V = 8'(DWELL);
   logic [7:0]          r_dwell [NUM_PLAT];
   logic [7:0]          w_dwell;
   logic [7:0]          w_new_dwell;
`endif

   logic                w_cfg_acc;
   logic                w_stall;
   logic                w_cur_en;
   logic                w_cur_dir;
   logic                w_new_dir;
   logic [9:0]          w_cur_x;
   logic [9:0]          w_cur_xmin;
   logic [9:0]          w_cur_xmax;
   logic [9:0]          w_new_x;
   logic [2:0]          w_cur_speed;
   logic [10:0]         w_nx;
   logic signed [10:0]  w_new_dx;

   // A write coinciding with frame_tick lands on the same edge the scan starts, before platform 0 is read.
   assign w_cfg_acc   = (r_state == S_IDLE) && bus.cfg_we && ({1'b0, bus.cfg_idx} < NUM_PLAT_V);

   assign w_cur_x     = r_x[r_idx];
   assign w_cur_xmin  = r_xmin[r_idx];
   assign w_cur_xmax  = r_xmax[r_idx];
   assign w_cur_speed = r_speed[r_idx];
   assign w_cur_en    = r_en[r_idx];
   assign w_cur_dir   = r_dir[r_idx];
`ifdef PLAT_DWELL_EN
   assign w_dwell     = r_dwell[r_idx];
`endif

   always_comb begin
      w_nx      = w_cur_dir ? ({1'b0, w_cur_x} + {8'd0, w_cur_speed})
                            : ({1'b0, w_cur_x} - {8'd0, w_cur_speed});
      w_new_x   = w_cur_x;
      w_new_dir = w_cur_dir;
`ifdef PLAT_DWELL_EN
      w_new_dwell = w_dwell;
      w_stall     = !w_cur_en || (w_cur_xmin >= w_cur_xmax) || (w_dwell != 8'd0);
      if (w_dwell != 8'd0)
         w_new_dwell = w_dwell - 8'd1;
`else
      w_stall     = !w_cur_en || (w_cur_xmin >= w_cur_xmax);
`endif
      if (!w_stall) begin
         if (w_cur_dir && (w_nx >= {1'b0, w_cur_xmax})) begin
            w_new_x   = w_cur_xmax;
            w_new_dir = 1'b0;
`ifdef PLAT_DWELL_EN
            w_new_dwell = DWELL_V;
`endif
         end else if (!w_cur_dir && ($signed(w_nx) <= $signed({1'b0, w_cur_xmin}))) begin
            // Signed compare so a step past x=0 still clamps to xmin.
            w_new_x   = w_cur_xmin;
            w_new_dir = 1'b1;
`ifdef PLAT_DWELL_EN
            w_new_dwell = DWELL_V;
`endif
         end else begin
            w_new_x = w_nx[9:0];
         end
      end
      w_new_dx = $signed({1'b0, w_new_x}) - $signed({1'b0, w_cur_x});
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_busy        <= 1'b0;
         r_cfg_ack     <= 1'b0;
         r_update_done <= 1'b0;
         r_overrun     <= 1'b0;
         for (int i = 0; i < NUM_PLAT; i++) begin
            r_x[i]     <= (i == 0) ? 10'(P0_XMIN) : 10'd0;
            r_xmin[i]  <= (i == 0) ? 10'(P0_XMIN) : 10'd0;
            r_xmax[i]  <= (i == 0) ? 10'(P0_XMAX) : 10'd0;
            r_speed[i] <= (i == 0) ? 3'd1 : 3'd0;
            r_en[i]    <= (i == 0);
            r_dir[i]   <= 1'b1;
            r_dx[i]    <= '0;
`ifdef PLAT_DWELL_EN
            r_dwell[i] <= 8'd0;
`endif
         end
      end else begin
         r_cfg_ack     <= w_cfg_acc;
         r_update_done <= 1'b0;
         r_overrun     <= bus.frame_tick && (r_state != S_IDLE);

         if (w_cfg_acc) begin
            r_xmin[bus.cfg_idx]  <= bus.cfg_xmin;
            r_xmax[bus.cfg_idx]  <= bus.cfg_xmax;
            r_speed[bus.cfg_idx] <= bus.cfg_speed;
            r_en[bus.cfg_idx]    <= bus.cfg_en;
            r_x[bus.cfg_idx]     <= bus.cfg_xmin;
            r_dir[bus.cfg_idx]   <= 1'b1;
            r_dx[bus.cfg_idx]    <= '0;
`ifdef PLAT_DWELL_EN
            r_dwell[bus.cfg_idx] <= 8'd0;
`endif
         end

         if (r_state == S_SCAN) begin
            r_x[r_idx]   <= w_new_x;
            r_dir[r_idx] <= w_new_dir;
            r_dx[r_idx]  <= w_new_dx;
`ifdef PLAT_DWELL_EN
            r_dwell[r_idx] <= w_new_dwell;
`endif
         end

         case (r_state)
            S_IDLE: begin
               if (bus.frame_tick) begin
                  r_state <= S_SCAN;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_SCAN: begin
               if (r_idx == LAST_IDX)
                  r_state <= S_DONE;
               else
                  r_idx <= r_idx + 1'b1;
            end
            S_DONE: begin
               r_state       <= S_IDLE;
               r_busy        <= 1'b0;
               r_update_done <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.cfg_ack     = r_cfg_ack;
   assign bus.update_done = r_update_done;
   assign bus.overrun     = r_overrun;

   generate
      for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_out
         assign bus.plat_x[gi]   = r_x[gi];
         assign bus.plat_dir[gi] = r_dir[gi];
         assign bus.plat_dx[gi]  = r_dx[gi];
      end
   endgenerate
endmodule

// File: tb/tb_platform_scheduler.sv
// Randomized self-checking bench for platform_scheduler against a frame-level motion model.
module tb_platform_scheduler;
   localparam int NP = 4;
   localparam int IW = $clog2(NP);
   localparam int DW = 30;
`ifdef PLAT_DWELL_EN
   localparam int DWELL_M = DW;
`else
   localparam int DWELL_M = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int m_x [NP];
   int m_dir [NP];
   int m_xmin [NP];
   int m_xmax [NP];
   int m_sp [NP];
   int m_en [NP];
   int m_dx [NP];
   int m_dw [NP];

   platform_scheduler_if #(.NUM_PLAT(NP)) bus ();

   platform_scheduler #(
      .NUM_PLAT(NP), .DWELL(DW), .P0_XMIN(180), .P0_XMAX(305)
   ) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_x[i]    = (i == 0) ? 180 : 0;
         m_xmin[i] = (i == 0) ? 180 : 0;
         m_xmax[i] = (i == 0) ? 305 : 0;
         m_sp[i]   = (i == 0) ? 1 : 0;
         m_en[i]   = (i == 0) ? 1 : 0;
         m_dir[i]  = 1;
         m_dx[i]   = 0;
         m_dw[i]   = 0;
      end
   endtask

   // One frame's worth of motion for platform i, straight from the movement rules.
   task automatic model_step(input int i);
      int old_x;
      int nx;
      old_x = m_x[i];
      if (m_en[i] == 0 || m_xmin[i] >= m_xmax[i] || m_dw[i] > 0) begin
         if (m_dw[i] > 0) m_dw[i]--;
         m_dx[i] = 0;
      end else begin
         nx = (m_dir[i] == 1) ? old_x + m_sp[i] : old_x - m_sp[i];
         if (m_dir[i] == 1 && nx >= m_xmax[i]) begin
            m_x[i] = m_xmax[i]; m_dir[i] = 0; m_dw[i] = DWELL_M;
         end else if (m_dir[i] == 0 && nx <= m_xmin[i]) begin
            m_x[i] = m_xmin[i]; m_dir[i] = 1; m_dw[i] = DWELL_M;
         end else begin
            m_x[i] = nx;
         end
         m_dx[i] = m_x[i] - old_x;
      end
   endtask

   task automatic check_plat(input int i, input string where);
      check_eq($sformatf("%s_x%0d", where, i),   int'(bus.plat_x[i]),   m_x[i]);
      check_eq($sformatf("%s_dir%0d", where, i), int'(bus.plat_dir[i]), m_dir[i]);
      check_eq($sformatf("%s_dx%0d", where, i),  int'(bus.plat_dx[i]),  m_dx[i]);
   endtask

   task automatic check_all(input string where);
      for (int i = 0; i < NP; i++) check_plat(i, where);
   endtask

   task automatic frame();
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      check_eq("busy_start", int'(bus.busy), 1);
      for (int i = 0; i < NP; i++) begin
         @(posedge clk); #1;
         model_step(i);
         check_plat(i, "scan");
         check_eq("done_early", int'(bus.update_done), 0);
      end
      @(posedge clk); #1;
      check_eq("update_done", int'(bus.update_done), 1);
      check_eq("busy_end", int'(bus.busy), 0);
      $display("frame: x0=%0d x1=%0d x2=%0d x3=%0d", bus.plat_x[0], bus.plat_x[1], bus.plat_x[2], bus.plat_x[3]);
   endtask

   task automatic cfg_write(input int idx, input int xmin, input int xmax, input int sp, input int en);
      int got;
      @(negedge clk);
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = IW'(idx);
      bus.cfg_xmin  = 10'(xmin);
      bus.cfg_xmax  = 10'(xmax);
      bus.cfg_speed = 3'(sp);
      bus.cfg_en    = (en != 0);
      got = 0;
      for (int k = 0; k < 40 && got == 0; k++) begin
         @(posedge clk); #1;
         if (bus.cfg_ack) got = 1;
      end
      bus.cfg_we = 1'b0;
      check_eq("cfg_ack_seen", got, 1);
      m_xmin[idx] = xmin; m_xmax[idx] = xmax; m_sp[idx] = sp; m_en[idx] = (en != 0);
      m_x[idx] = xmin; m_dir[idx] = 1; m_dw[idx] = 0; m_dx[idx] = 0;
      check_plat(idx, "cfg");
      $display("cfg: idx=%0d xmin=%0d xmax=%0d speed=%0d en=%0d", idx, xmin, xmax, sp, en);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int ovr_cnt;
      int done_cnt;
      int ack_at;
      int xmin;
      int xmax;

      bus.frame_tick = 1'b0;
      bus.cfg_we     = 1'b0;
      bus.cfg_idx    = '0;
      bus.cfg_xmin   = '0;
      bus.cfg_xmax   = '0;
      bus.cfg_speed  = '0;
      bus.cfg_en     = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      check_eq("reset_busy", int'(bus.busy), 0);
      check_eq("reset_done", int'(bus.update_done), 0);
      check_eq("reset_ovr", int'(bus.overrun), 0);
      check_eq("reset_ack", int'(bus.cfg_ack), 0);
      @(negedge clk);
      rst_n = 1'b1;

      frame();

      cfg_write(1, 100, 110, 7, 1);
      repeat (DWELL_M + 4) frame();

      cfg_write(2, 3, 6, 5, 1);
      repeat (2 * DWELL_M + 4) frame();

      // Second tick two cycles into a scan.
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      @(posedge clk); #1;
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      check_eq("overrun_pulse", int'(bus.overrun), 1);
      ovr_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < NP + 5; k++) begin
         @(posedge clk); #1;
         ovr_cnt += int'(bus.overrun);
         done_cnt += int'(bus.update_done);
      end
      check_eq("overrun_after", ovr_cnt, 0);
      check_eq("done_count", done_cnt, 1);
      for (int i = 0; i < NP; i++) model_step(i);
      check_all("ovr");
      $display("overrun: extra_ovr=%0d done=%0d", ovr_cnt, done_cnt);

      // Config write held across a scan.
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = IW'(3);
      bus.cfg_xmin  = 10'd500;
      bus.cfg_xmax  = 10'd600;
      bus.cfg_speed = 3'd2;
      bus.cfg_en    = 1'b1;
      ack_at = -1;
      for (int k = 1; k <= NP + 6 && ack_at < 0; k++) begin
         @(posedge clk); #1;
         if (bus.cfg_ack) ack_at = k;
      end
      bus.cfg_we = 1'b0;
      check_eq("cfg_ack_edge", ack_at, NP + 2);
      for (int i = 0; i < NP; i++) model_step(i);
      m_xmin[3] = 500; m_xmax[3] = 600; m_sp[3] = 2; m_en[3] = 1;
      m_x[3] = 500; m_dir[3] = 1; m_dw[3] = 0; m_dx[3] = 0;
      check_all("cfg_busy");
      $display("cfg_busy: ack_at=%0d x3=%0d", ack_at, bus.plat_x[3]);
      frame();

      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 3) == 0) begin
            xmin = $urandom_range(0, 1000);
            if ($urandom_range(0, 7) == 0)
               xmax = $urandom_range(0, xmin);
            else
               xmax = xmin + $urandom_range(1, 40);
            if (xmax > 1023) xmax = 1023;
            cfg_write($urandom_range(0, NP - 1), xmin, xmax, $urandom_range(0, 7),
                      ($urandom_range(0, 4) != 0) ? 1 : 0);
         end else begin
            frame();
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // Reset in the middle of a scan (while idx=1 is being visited).
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid");
      check_eq("rst_mid_busy", int'(bus.busy), 0);
      done_cnt = 0;
      repeat (NP + 3) begin
         @(posedge clk); #1;
         done_cnt += int'(bus.update_done);
      end
      check_eq("rst_no_done", done_cnt, 0);
      $display("rst_mid: done=%0d x0=%0d", done_cnt, bus.plat_x[0]);
      @(negedge clk);
      rst_n = 1'b1;
      frame();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
